// File: rtl/cpu_nios_acionar.sv
// cpu_nios_acionar: Avalon-MM output PIO for coffee-machine actuators.
// Registers: DATA, MASK, COUNT (auto-off timer), OUTSET/OUTCLEAR (atomic bit
// set/clear), STATUS (sticky EXPIRED flag).
// Optional feature macro: CPU_NIOS_ACIONAR_IRQ_EN adds STATUS and the irq port.
module cpu_nios_acionar #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      COUNT_W     = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
`ifdef CPU_NIOS_ACIONAR_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_COUNT  = 3'd2;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               expired_q, expired_d;

  logic               wr;
  logic               cnt_load;
  logic               expire;
  logic [WIDTH-1:0]   wd_w;
  logic [COUNT_W-1:0] wd_c;
  logic               unused_wd;

  assign wd_w      = writedata[WIDTH-1:0];
  assign wd_c      = writedata[COUNT_W-1:0];
  // Upper writedata bits are ignored when WIDTH/COUNT_W are below 32.
  assign unused_wd = &{1'b0, writedata};

  // Next-state logic: CPU writes, timer countdown, expiry clear and read mux.
  always_comb begin
    wr       = chipselect & ~write_n;
    cnt_load = wr && (address == ADDR_COUNT);
    // A COUNT write on the expiry edge reloads the timer and suppresses the event.
    expire   = (cnt_q == COUNT_W'(1)) && !cnt_load;

    data_d = data_q;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_d = wd_w;
        ADDR_OUTSET: data_d = data_q | wd_w;
        ADDR_OUTCLR: data_d = data_q & ~wd_w;
        default:     data_d = data_q;
      endcase
    end
    // Expiry is applied after any CPU update so masked bits always end up cleared;
    // the pre-edge MASK is used even if MASK is written on the same edge.
    if (expire) data_d = data_d & ~mask_q;

    mask_d = mask_q;
    if (wr && (address == ADDR_MASK)) mask_d = wd_w;

    cnt_d = cnt_q;
    if (cnt_load) cnt_d = wd_c;
    else if (cnt_q != '0) cnt_d = cnt_q - COUNT_W'(1);

    expired_d = 1'b0;
`ifdef CPU_NIOS_ACIONAR_IRQ_EN
    expired_d = expired_q;
    if (expire) expired_d = 1'b1;
    else if (wr && (address == ADDR_STATUS) && writedata[0]) expired_d = 1'b0;
`endif

    readdata_d = '0;
    case (address)
      ADDR_DATA:   readdata_d[WIDTH-1:0]   = data_q;
      ADDR_MASK:   readdata_d[WIDTH-1:0]   = mask_q;
      ADDR_COUNT:  readdata_d[COUNT_W-1:0] = cnt_q;
      ADDR_STATUS: readdata_d[0]           = expired_q;
      default:     readdata_d              = '0;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      mask_q     <= '0;
      cnt_q      <= '0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
    end
  end

`ifdef CPU_NIOS_ACIONAR_IRQ_EN
  // Sticky expiry flag, also driven straight out as the level interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) expired_q <= 1'b0;
    else          expired_q <= expired_d;
  end
  assign irq = expired_q;
`else
  assign expired_q = expired_d;
`endif

  assign readdata = readdata_q;
  assign out_port = data_q;

endmodule

// File: tb/tb_cpu_nios_acionar.sv
// Scoreboard testbench for cpu_nios_acionar (WIDTH=8, COUNT_W=8, RESET_VALUE=8'h81).
// Works in both builds; define CPU_NIOS_ACIONAR_IRQ_EN to exercise STATUS/irq.
module tb_cpu_nios_acionar;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq_w;

  int checks = 0;
  int errors = 0;

`ifdef CPU_NIOS_ACIONAR_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
  assign irq_w = 1'b0;
`endif

  cpu_nios_acionar #(
    .WIDTH(8), .COUNT_W(8), .RESET_VALUE(8'h81)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
`ifdef CPU_NIOS_ACIONAR_IRQ_EN
    , .irq(irq_w)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  outp;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t q[$];

  // Reference model state: what the register file holds, in plain terms.
  logic [7:0] m_data, m_mask;
  int         m_cnt;
  logic       m_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'd0, m_data};
      3'd1: return {24'd0, m_mask};
      3'd2: return 32'(m_cnt);
      3'd6: return {31'd0, m_exp};
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive on the falling edge, predict the state after the next rising edge.
  task automatic cyc(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    exp_t e;
    logic wr, fire;
    logic [7:0] nd;
    @(negedge clk);
    address = a; chipselect = cs; write_n = wn; writedata = wd;
    wr   = cs && !wn;
    e.rd = model_read(a);
    fire = (m_cnt == 1) && !(wr && a == 3'd2);
    nd = m_data;
    if (wr && a == 3'd0) nd = wd[7:0];
    if (wr && a == 3'd4) nd = m_data | wd[7:0];
    if (wr && a == 3'd5) nd = m_data & ~wd[7:0];
    if (fire) nd = nd & ~m_mask;
    m_data = nd;
    if (wr && a == 3'd1) m_mask = wd[7:0];
    if (wr && a == 3'd2) m_cnt = int'(wd % 256);
    else if (m_cnt > 0) m_cnt = m_cnt - 1;
    if (IRQ_BUILD) begin
      if (fire) m_exp = 1'b1;
      else if (wr && a == 3'd6 && wd[0]) m_exp = 1'b0;
    end
    e.outp = m_data;
    e.irq  = m_exp;
    q.push_back(e);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
    cyc(a, 1'b1, 1'b0, wd);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    cyc(a, 1'b1, 1'b1, 32'hDEAD_BEEF);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'd2, 1'b0, 1'b1, 32'd0);
  endtask

  // Asynchronous reset pulse mid-cycle, checked while still asserted.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    m_data = 8'h81; m_mask = 8'h00; m_cnt = 0; m_exp = 1'b0;
    #1;
    chk("reset_out_port", {24'd0, out_port}, 32'h81);
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_irq", {31'd0, irq_w}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: compare each predicted cycle just after the rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_port", {24'd0, out_port}, {24'd0, e.outp});
      chk("readdata", readdata, e.rd);
      chk("irq", {31'd0, irq_w}, {31'd0, e.irq});
    end
  end

  initial begin
    address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    reset_n = 1'b0;
    m_data = 8'h81; m_mask = 8'h00; m_cnt = 0; m_exp = 1'b0;
    #12;
    chk("por_out_port", {24'd0, out_port}, 32'h81);
    chk("por_readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state readback
    rd_reg(3'd2); rd_reg(3'd0); rd_reg(3'd6);

    // Set/clear
    wr_reg(3'd0, 32'h0F); wr_reg(3'd4, 32'h30); wr_reg(3'd5, 32'h03);
    rd_reg(3'd0); rd_reg(3'd4); rd_reg(3'd5); idle(1);

    // Auto-off
    wr_reg(3'd0, 32'hFF); wr_reg(3'd1, 32'h0C); wr_reg(3'd2, 32'd5);
    for (int i = 0; i < 7; i++) rd_reg(3'd2);
    rd_reg(3'd6); idle(1);

    // Collisions: reload on expiry edge, OUTSET on expiry edge, MASK write on expiry edge
    wr_reg(3'd0, 32'hFF); wr_reg(3'd2, 32'd1); wr_reg(3'd2, 32'd3); idle(4);
    wr_reg(3'd1, 32'h04); wr_reg(3'd2, 32'd1); wr_reg(3'd4, 32'h04); idle(1);
    wr_reg(3'd0, 32'hFF); wr_reg(3'd2, 32'd1); wr_reg(3'd1, 32'hF0); idle(2);

    // W1C, then W1C colliding with a fresh expiry
    wr_reg(3'd6, 32'h1); rd_reg(3'd6);
    wr_reg(3'd2, 32'd2); idle(1); wr_reg(3'd6, 32'h1); rd_reg(3'd6); idle(1);
    wr_reg(3'd6, 32'h1); idle(1);

    // Cancel
    wr_reg(3'd0, 32'h5A); wr_reg(3'd1, 32'hFF); wr_reg(3'd2, 32'd100);
    idle(9); wr_reg(3'd2, 32'd0); idle(110); rd_reg(3'd0); rd_reg(3'd6);

    // Truncation of COUNT to 8 bits: 0x103 -> 3
    wr_reg(3'd0, 32'hFF); wr_reg(3'd2, 32'h103); rd_reg(3'd2); idle(4);

    // Reset mid-countdown
    wr_reg(3'd0, 32'h3C); wr_reg(3'd2, 32'd100); idle(49);
    do_reset();
    idle(110); rd_reg(3'd0); rd_reg(3'd2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd2) wd = $urandom_range(0, 8) | (($urandom_range(0, 3) == 0) ? 32'h100 : 32'h0);
      cyc(a, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), wd);
    end
    idle(2);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
